tx_fifo_arb: RTL
================

Name: tx_fifo_arb

Overview:
Round-robin frame arbiter that shares the single UART TX byte FIFO between up to NUM_REQ frame-building sources. Examples of sources are the pulse-measurement reporter and status/heartbeat reporters.
- A grant is held for a whole frame, so bytes from different sources never interleave.
- Applies FIFO high-water backpressure to the granted source.
- Aborts frames whose source stalls past a timeout.
- Sits between the frame builders and the TX FIFO write port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
USEDW_W, 12, width of tx_fifo_usedw
HIGH_WATER, 2000, source is stalled when usedw >= this value
TIMEOUT, 50000, idle cycles inside a granted frame before abort (16-bit)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
src_req  in  NUM_REQ  per-source frame request, level
src_wen  in  NUM_REQ  per-source byte write strobe
src_wdata  in  8*NUM_REQ  per-source byte; source i uses bits [8i+7:8i]
src_last  in  NUM_REQ  marks the final byte of a frame; qualified by src_wen
src_gnt  out  NUM_REQ  one-hot grant, registered
src_ready  out  NUM_REQ  granted source may write this cycle, combinational
tx_fifo_wen  out  1  FIFO write strobe, registered
tx_fifo_wdata  out  8  FIFO write data, registered
tx_fifo_full  in  1  FIFO full
tx_fifo_usedw  in  USEDW_W  FIFO fill level
err_timeout  out  1  one-cycle pulse when a frame is aborted
drop_cnt  out  16  saturating count of bytes written while not ready

Behaviour:
- Reset values:
  - src_gnt=0, tx_fifo_wen=0, tx_fifo_wdata=0, err_timeout=0, drop_cnt=0.
  - State=IDLE, rr_ptr=NUM_REQ-1, timeout counter=0.
- States:
  - IDLE: if any src_req is high, select the first requesting index after rr_ptr, searching upward with wrap. Register src_gnt one-hot, set rr_ptr=index, go to XFER (or TAG, see Optional Feature). Grant becomes visible the cycle after the request is seen.
  - XFER: src_ready[g] = !tx_fifo_full && (tx_fifo_usedw < HIGH_WATER). All other src_ready bits are 0.
    - An accepted byte is src_wen[g] && src_ready[g]. It produces tx_fifo_wen=1 and tx_fifo_wdata=the source byte on the next cycle (latency 1).
    - Accepted byte with src_last[g] -> GAP.
  - GAP: exactly one cycle; src_gnt=0; -> IDLE. This guarantees at least 2 cycles between frames from different sources.
- Write outcomes:
  - src_wen on a non-granted source, or on the granted source while src_ready=0: byte is discarded; drop_cnt += 1, saturating at 0xFFFF.
  - src_last on a discarded byte does not end the frame.
- Timeout:
  - In XFER the counter clears on every accepted byte and increments on every other cycle.
  - Stall from backpressure counts toward the timeout.
  - Counter reaching TIMEOUT-1: err_timeout pulses, src_gnt clears, state -> GAP. No partial-frame cleanup is written to the FIFO.
- Grant hold: deassertion of src_req[g] mid-frame does not release the grant. Only an accepted last byte or a timeout releases it.
- Fairness: after serving index g, index g has the lowest priority. With all sources requesting, the grant order is 0,1,2,3,0,...
- Simultaneous events:
  - A full/high-water condition in the same cycle as src_wen blocks that byte; the byte is dropped.
  - A new request arriving during GAP is arbitrated in the following IDLE cycle.
- Reset mid-frame forces all outputs to their reset values immediately. Frame state is discarded.
- tx_fifo_wen is never asserted while tx_fifo_full was high in the accepting cycle.

Optional Feature:
Macro SRC_TAG_EN.
- Defined: after the grant, the TAG state lasts one cycle with src_ready=0. It writes tag byte {4'hA, 1'b0, g[2:0]} to the FIFO if !tx_fifo_full and usedw < HIGH_WATER, then moves to XFER. If the FIFO is blocked, TAG waits; TAG waiting counts toward the timeout.
- Undefined: no TAG state; IDLE goes directly to XFER and frames enter the FIFO unmodified.

Test Plan:
- Single source 1, usedw=0: 8-byte frame 0x10..0x17 with last on 0x17 -> tx_fifo_wen high 8 cycles, data 0x10..0x17 delayed 1 cycle; src_gnt=4'b0010 during frame; GAP then IDLE.
- All 4 src_req high continuously, each sending 3-byte frames -> grant order 0,1,2,3,0; no byte interleaving in FIFO stream; drop_cnt=0.
- Source 2 mid-frame; usedw driven to 2000 for 5 cycles while source holds wen -> src_ready low those cycles, 5 bytes dropped, drop_cnt=5; frame resumes when usedw=1999.
- TIMEOUT=20: source 0 granted, writes 2 bytes then idles -> err_timeout pulses once at the 20th idle cycle; src_gnt clears; a pending source 1 is granted 2 cycles later.
- Source 3 drives src_wen while source 0 is granted -> source 3 bytes absent from FIFO, drop_cnt increments per byte; rst low mid-frame -> all outputs 0 on the next edge.
- SRC_TAG_EN defined, source 2 frame 0x55,0x66 -> FIFO receives 0xA2,0x55,0x66.

Source files
------------

// File: rtl/tx_fifo_arb.sv
// ---------------------------------------------------------------------------
// tx_fifo_arb
//
// Round-robin frame arbiter that shares the single UART TX byte FIFO between
// NUM_REQ frame-building sources. A grant is held for a whole frame so bytes
// from different sources never interleave. The granted source is throttled by
// FIFO full / high-water, and a frame whose source goes quiet for TIMEOUT
// cycles is abandoned.
//
// Optional feature macro: SRC_TAG_EN
//   When defined, each frame is prefixed in the FIFO with a tag byte
//   {4'hA, 1'b0, index[2:0]} written from a one-cycle TAG state.
//   When undefined, frames enter the FIFO unmodified.
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-low reset
//   src_req        per-source frame request (level)
//   src_wen        per-source byte write strobe
//   src_wdata      per-source byte, source i on bits [8i+7:8i]
//   src_last       final byte of a frame, qualified by src_wen
//   src_gnt        one-hot grant (registered)
//   src_ready      granted source may write this cycle (combinational)
//   tx_fifo_wen    FIFO write strobe (registered)
//   tx_fifo_wdata  FIFO write data (registered)
//   tx_fifo_full   FIFO full
//   tx_fifo_usedw  FIFO fill level
//   err_timeout    one-cycle pulse when a frame is aborted
//   drop_cnt       saturating count of bytes written while not ready
// ---------------------------------------------------------------------------
module tx_fifo_arb #(
    parameter int NUM_REQ    = 4,
    parameter int USEDW_W    = 12,
    parameter int HIGH_WATER = 2000,
    parameter int TIMEOUT    = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   src_req,
    input  logic [NUM_REQ-1:0]   src_wen,
    input  logic [8*NUM_REQ-1:0] src_wdata,
    input  logic [NUM_REQ-1:0]   src_last,
    output logic [NUM_REQ-1:0]   src_gnt,
    output logic [NUM_REQ-1:0]   src_ready,
    output logic                 tx_fifo_wen,
    output logic [7:0]           tx_fifo_wdata,
    input  logic                 tx_fifo_full,
    input  logic [USEDW_W-1:0]   tx_fifo_usedw,
    output logic                 err_timeout,
    output logic [15:0]          drop_cnt
);

    localparam int                 PTR_W    = $clog2(NUM_REQ);
    localparam logic [USEDW_W-1:0] HW_LEVEL = USEDW_W'(HIGH_WATER);
    localparam logic [15:0]        TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef SRC_TAG_EN
        S_TAG,
`endif
        S_XFER,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [PTR_W-1:0]   r_rrPtr;
    logic [15:0]        r_toCnt;
    logic               r_fifoWen;
    logic [7:0]         r_fifoWdata;
    logic               r_errTimeout;
    logic [15:0]        r_dropCnt;

    state_t             w_nextState;
    logic [NUM_REQ-1:0] w_gntNext;
    logic [PTR_W-1:0]   w_rrNext;
    logic [15:0]        w_toNext;
    logic               w_wenNext;
    logic [7:0]         w_wdataNext;
    logic               w_errNext;
    logic [15:0]        w_dropNext;

    logic               w_fifoOk;
    logic               w_accept;
    logic [7:0]         w_srcByte;
    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    logic [NUM_REQ-1:0] w_drop;
    logic [3:0]         w_dropNum;
    logic [16:0]        w_dropSum;

    // While a frame is active r_rrPtr holds the granted index, so it doubles
    // as the mux select for the granted source's byte lane.
    assign w_fifoOk  = !tx_fifo_full && (tx_fifo_usedw < HW_LEVEL);
    assign src_ready = ((r_state == S_XFER) && w_fifoOk) ? r_gnt : '0;
    assign w_srcByte = src_wdata[{r_rrPtr, 3'b000} +: 8];
    assign w_accept  = (r_state == S_XFER) && w_fifoOk && src_wen[r_rrPtr];

    // Round-robin search: first requester strictly after r_rrPtr, with wrap,
    // so the most recently served source ends up with the lowest priority.
    always_comb begin
        logic [PTR_W:0] idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, r_rrPtr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_REQ)) begin
                idx = idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_found && src_req[idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = idx[PTR_W-1:0];
            end
        end
    end

    // Any strobe that is not matched by a ready bit is a discarded byte; more
    // than one source can drop in the same cycle, so add them all up.
    always_comb begin
        w_drop    = src_wen & ~src_ready;
        w_dropNum = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dropNum = w_dropNum + 4'(w_drop[i]);
        end
        w_dropSum  = {1'b0, r_dropCnt} + 17'(w_dropNum);
        w_dropNext = w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
    end

    // Next-state and next-output logic. The timeout counter runs in every
    // non-productive cycle of a granted frame, including backpressure stalls.
    always_comb begin
        w_nextState = r_state;
        w_gntNext   = r_gnt;
        w_rrNext    = r_rrPtr;
        w_toNext    = r_toCnt;
        w_wenNext   = 1'b0;
        w_wdataNext = r_fifoWdata;
        w_errNext   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gntNext = NUM_REQ'(1) << w_winner;
                    w_rrNext  = w_winner;
                    w_toNext  = '0;
`ifdef SRC_TAG_EN
                    w_nextState = S_TAG;
`else
                    w_nextState = S_XFER;
`endif
                end
            end
`ifdef SRC_TAG_EN
            S_TAG: begin
                if (w_fifoOk) begin
                    w_wenNext   = 1'b1;
                    w_wdataNext = {4'hA, 1'b0, 3'(r_rrPtr)};
                    w_toNext    = '0;
                    w_nextState = S_XFER;
                end else if (r_toCnt == TMO_LAST) begin
                    w_errNext   = 1'b1;
                    w_gntNext   = '0;
                    w_toNext    = '0;
                    w_nextState = S_GAP;
                end else begin
                    w_toNext = r_toCnt + 16'd1;
                end
            end
`endif
            S_XFER: begin
                if (w_accept) begin
                    w_wenNext   = 1'b1;
                    w_wdataNext = w_srcByte;
                    w_toNext    = '0;
                    if (src_last[r_rrPtr]) begin
                        w_gntNext   = '0;
                        w_nextState = S_GAP;
                    end
                end else if (r_toCnt == TMO_LAST) begin
                    w_errNext   = 1'b1;
                    w_gntNext   = '0;
                    w_toNext    = '0;
                    w_nextState = S_GAP;
                end else begin
                    w_toNext = r_toCnt + 16'd1;
                end
            end
            S_GAP: begin
                w_gntNext   = '0;
                w_nextState = S_IDLE;
            end
            default: begin
                w_gntNext   = '0;
                w_nextState = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_gnt        <= '0;
            r_rrPtr      <= PTR_W'(NUM_REQ - 1);
            r_toCnt      <= '0;
            r_fifoWen    <= 1'b0;
            r_fifoWdata  <= '0;
            r_errTimeout <= 1'b0;
            r_dropCnt    <= '0;
        end else begin
            r_state      <= w_nextState;
            r_gnt        <= w_gntNext;
            r_rrPtr      <= w_rrNext;
            r_toCnt      <= w_toNext;
            r_fifoWen    <= w_wenNext;
            r_fifoWdata  <= w_wdataNext;
            r_errTimeout <= w_errNext;
            r_dropCnt    <= w_dropNext;
        end
    end

    assign src_gnt       = r_gnt;
    assign tx_fifo_wen   = r_fifoWen;
    assign tx_fifo_wdata = r_fifoWdata;
    assign err_timeout   = r_errTimeout;
    assign drop_cnt      = r_dropCnt;

endmodule
